// File: rtl/feature_map_streamer_pkg.sv
// Shared definitions for the feature map streamer: default pixel width,
// address-width helper and the transmit FSM encoding.
package feature_map_streamer_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  // Width of a counter that must hold values 0..n-1, never narrower than 1 bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/feature_map_streamer_frame_ram.sv
// Frame storage: one write port, one synchronous read port (1-cycle latency).
// The array has no reset so a frame survives a streamer reset.
module frame_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 25,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/feature_map_streamer.sv
// Replays a stored input_x-by-input_y feature map as a raster stream of
// sof / output_valid / d_out, one frame per start pulse.
module feature_map_streamer
  import feature_map_streamer_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int input_x    = 5,
  parameter  int input_y    = 5,
  parameter  int GAP        = 0,
  localparam int AW         = addr_w(input_x * input_y)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  sof,
  output logic                  output_valid,
  output logic [DATA_WIDTH-1:0] d_out
);

  localparam int            N    = input_x * input_y;
  localparam int            GW   = (GAP > 0) ? addr_w(GAP + 1) : 1;
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  localparam logic [AW:0]   N_W  = (AW + 1)'(N);

  fsm_state_e            state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [1:0]            vld_pipe_q;  // [0] RAM data valid, [1] output register valid
  logic [1:0]            sof_pipe_q;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] d_out_q;
  logic                  rd_issue;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Writes are locked out for the whole frame so the image cannot tear.
  assign wr_ok = wr_en && (state_q == ST_IDLE) && ({1'b0, wr_addr} < N_W);

  frame_ram #(
    .DW    (DATA_WIDTH),
    .DEPTH (N),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (rd_issue),
    .raddr (addr_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    gap_d    = gap_q;
    rd_issue = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          addr_d  = '0;
          gap_d   = '0;
        end
      end
      ST_READ: begin
        if (gap_q == '0) begin
          rd_issue = 1'b1;
          gap_d    = GW'(GAP);
          if (addr_q == LAST) state_d = ST_DRAIN;
          else                addr_d  = addr_q + AW'(1);
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      ST_DRAIN: begin
        // Last pixel sits in the output register and nothing is behind it.
        if (!vld_pipe_q[0] && vld_pipe_q[1]) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      gap_q      <= '0;
      vld_pipe_q <= '0;
      sof_pipe_q <= '0;
      done_q     <= 1'b0;
      d_out_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      gap_q      <= gap_d;
      vld_pipe_q <= {vld_pipe_q[0], rd_issue};
      sof_pipe_q <= {sof_pipe_q[0], rd_issue && (addr_q == '0)};
      done_q     <= done_d;
      if (vld_pipe_q[0]) d_out_q <= ram_rdata;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign sof          = sof_pipe_q[1];
  assign output_valid = vld_pipe_q[1];
  assign d_out        = d_out_q;

endmodule

// File: tb/tb_feature_map_streamer.sv
// Scoreboard bench for feature_map_streamer: one GAP=0 and one GAP=2 instance
// sharing the write port, each launched by its own start line.
module tb_feature_map_streamer;

  localparam int DW = 32;
  localparam int NX = 5;
  localparam int NY = 5;
  localparam int N  = NX * NY;
  localparam int AW = 5;
  localparam int MAXC = 100;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    bit          sof;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start0 = 1'b0, start2 = 1'b0;
  logic          busy0, done0, sof0, ov0;
  logic          busy2, done2, sof2, ov2;
  logic [DW-1:0] d0, d2;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb[$];

  logic          cap_v [MAXC];
  logic          cap_s [MAXC];
  logic          cap_dn[MAXC];
  logic          cap_b [MAXC];
  logic [DW-1:0] cap_d [MAXC];

  always #5 clk = ~clk;

  feature_map_streamer #(.DATA_WIDTH(DW), .input_x(NX), .input_y(NY), .GAP(0)) u_g0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start0), .busy(busy0), .done(done0), .sof(sof0),
    .output_valid(ov0), .d_out(d0)
  );

  feature_map_streamer #(.DATA_WIDTH(DW), .input_x(NX), .input_y(NY), .GAP(2)) u_g2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start2), .busy(busy2), .done(done2), .sof(sof2),
    .output_valid(ov2), .d_out(d2)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Pulse start, then record outputs for cycles k = 0..ncyc-1 after the start edge.
  // Optional extra start pulse and write are driven from cycle pulse_k / wr_k.
  task automatic capture(input bit use2, input int ncyc, input int pulse_k,
                         input int wr_k, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    if (use2) start2 = 1'b1; else start0 = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      step();
      start0 = 1'b0; start2 = 1'b0; wr_en = 1'b0;
      cap_v[k]  = use2 ? ov2   : ov0;
      cap_s[k]  = use2 ? sof2  : sof0;
      cap_dn[k] = use2 ? done2 : done0;
      cap_b[k]  = use2 ? busy2 : busy0;
      cap_d[k]  = use2 ? d2    : d0;
      if (k == pulse_k) begin
        if (use2) start2 = 1'b1; else start0 = 1'b1;
      end
      if (k == wr_k) begin
        wr_en = 1'b1; wr_addr = wa; wr_data = wd;
      end
    end
    start0 = 1'b0; start2 = 1'b0; wr_en = 1'b0;
  endtask

  task automatic load_ram();
    for (int i = 0; i < N; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = DW'(i);
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic push_frame(input int first_cyc, input int stride);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.cyc = first_cyc + i * stride; e.data = DW'(i); e.sof = (i == 0);
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    n_tests++;
    if ({busy0, done0, sof0, ov0} !== 4'b0 || d0 !== '0) begin
      n_fail++;
      $display("FAIL reset_g0 got busy=%b done=%b sof=%b vld=%b d=%h want all 0", busy0, done0, sof0, ov0, d0);
    end
    n_tests++;
    if ({busy2, done2, sof2, ov2} !== 4'b0 || d2 !== '0) begin
      n_fail++;
      $display("FAIL reset_g2 got busy=%b done=%b sof=%b vld=%b d=%h want all 0", busy2, done2, sof2, ov2, d2);
    end
    repeat (3) step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_stream_gap0();
    exp_t e;
    int nsof = 0, ndone = 0, dk = -1;
    sb.delete();
    push_frame(2, 1);
    capture(1'b0, 30, -1, -1, '0, '0);
    for (int k = 0; k < 30; k++) begin
      if (cap_s[k]) nsof++;
      if (cap_dn[k]) begin ndone++; dk = k; end
      if (cap_v[k]) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL gap0_extra k=%0d got d=%h want no pixel", k, cap_d[k]);
        end else begin
          e = sb.pop_front();
          if (k != e.cyc || cap_d[k] !== e.data || cap_s[k] !== e.sof) begin
            n_fail++;
            $display("FAIL gap0_pixel k=%0d d=%h sof=%b want k=%0d d=%h sof=%b", k, cap_d[k], cap_s[k], e.cyc, e.data, e.sof);
          end
        end
      end
    end
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL gap0_missing got %0d left want 0", sb.size()); end
    n_tests++;
    if (nsof != 1) begin n_fail++; $display("FAIL gap0_sof_count got %0d want 1", nsof); end
    n_tests++;
    if (ndone != 1 || dk != 27) begin n_fail++; $display("FAIL gap0_done got n=%0d k=%0d want n=1 k=27", ndone, dk); end
    n_tests++;
    if (cap_b[0] !== 1'b1 || cap_b[26] !== 1'b1 || cap_b[27] !== 1'b0) begin
      n_fail++; $display("FAIL gap0_busy got b0=%b b26=%b b27=%b want 1 1 0", cap_b[0], cap_b[26], cap_b[27]);
    end
  endtask

  task automatic test_stream_gap2();
    exp_t e;
    int ndone = 0, dk = -1, bad_hold = 0;
    sb.delete();
    push_frame(2, 3);
    capture(1'b1, 80, -1, -1, '0, '0);
    for (int k = 0; k < 80; k++) begin
      if (cap_dn[k]) begin ndone++; dk = k; end
      if (k > 2 && k < 75 && !cap_v[k] && cap_d[k] !== cap_d[k-1]) bad_hold++;
      if (cap_v[k]) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL gap2_extra k=%0d got d=%h want no pixel", k, cap_d[k]);
        end else begin
          e = sb.pop_front();
          if (k != e.cyc || cap_d[k] !== e.data || cap_s[k] !== e.sof) begin
            n_fail++;
            $display("FAIL gap2_pixel k=%0d d=%h sof=%b want k=%0d d=%h sof=%b", k, cap_d[k], cap_s[k], e.cyc, e.data, e.sof);
          end
        end
      end
    end
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL gap2_missing got %0d left want 0", sb.size()); end
    n_tests++;
    if (bad_hold != 0) begin n_fail++; $display("FAIL gap2_hold got %0d changes in gaps want 0", bad_hold); end
    n_tests++;
    if (ndone != 1 || dk != 75 || cap_b[75] !== 1'b0 || cap_b[74] !== 1'b1) begin
      n_fail++; $display("FAIL gap2_done got n=%0d k=%0d b74=%b b75=%b want n=1 k=75 1 0", ndone, dk, cap_b[74], cap_b[75]);
    end
  endtask

  // Second start and a write to addr 3 land mid-frame; both must be ignored.
  task automatic test_busy_lockout();
    exp_t e;
    int ndone = 0, dk = -1;
    sb.delete();
    push_frame(2, 1);
    capture(1'b0, 40, 10, 1, AW'(3), 32'hDEAD);
    for (int k = 0; k < 40; k++) begin
      if (cap_dn[k]) begin ndone++; dk = k; end
      if (cap_v[k]) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL lock_extra k=%0d got d=%h want no pixel", k, cap_d[k]);
        end else begin
          e = sb.pop_front();
          if (k != e.cyc || cap_d[k] !== e.data || cap_s[k] !== e.sof) begin
            n_fail++;
            $display("FAIL lock_pixel k=%0d d=%h sof=%b want k=%0d d=%h sof=%b", k, cap_d[k], cap_s[k], e.cyc, e.data, e.sof);
          end
        end
      end
    end
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL lock_missing got %0d left want 0", sb.size()); end
    n_tests++;
    if (ndone != 1 || dk != 27) begin n_fail++; $display("FAIL lock_done got n=%0d k=%0d want n=1 k=27", ndone, dk); end
  endtask

  // Start on the done cycle; the following frame also proves addr 3 still holds 3.
  task automatic test_back_to_back();
    exp_t e;
    int ndone = 0, d1 = -1, d2k = -1;
    sb.delete();
    push_frame(2, 1);
    push_frame(30, 1);
    capture(1'b0, 58, 27, -1, '0, '0);
    for (int k = 0; k < 58; k++) begin
      if (cap_dn[k]) begin
        ndone++;
        if (d1 < 0) d1 = k; else d2k = k;
      end
      if (cap_v[k]) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra k=%0d got d=%h want no pixel", k, cap_d[k]);
        end else begin
          e = sb.pop_front();
          if (k != e.cyc || cap_d[k] !== e.data || cap_s[k] !== e.sof) begin
            n_fail++;
            $display("FAIL b2b_pixel k=%0d d=%h sof=%b want k=%0d d=%h sof=%b", k, cap_d[k], cap_s[k], e.cyc, e.data, e.sof);
          end
        end
      end
    end
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_missing got %0d left want 0", sb.size()); end
    n_tests++;
    if (ndone != 2 || d1 != 27 || d2k != 55) begin
      n_fail++; $display("FAIL b2b_done got n=%0d k1=%0d k2=%0d want n=2 k1=27 k2=55", ndone, d1, d2k);
    end
    n_tests++;
    if (cap_b[27] !== 1'b0 || cap_b[28] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_busy got b27=%b b28=%b want 0 1", cap_b[27], cap_b[28]);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int ndone = 0, bad = 0;
    capture(1'b0, 13, -1, -1, '0, '0);
    rst = 1'b0;
    #1;
    n_tests++;
    if ({busy0, done0, sof0, ov0} !== 4'b0 || d0 !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs got busy=%b done=%b sof=%b vld=%b d=%h want all 0", busy0, done0, sof0, ov0, d0);
    end
    repeat (2) begin step(); if (done0 !== 1'b0) ndone++; end
    #2 rst = 1'b1;
    repeat (4) begin step(); if (done0 !== 1'b0 || busy0 !== 1'b0 || ov0 !== 1'b0) bad++; end
    n_tests++;
    if (ndone != 0 || bad != 0) begin
      n_fail++; $display("FAIL rstmid_quiet got done_seen=%0d activity=%0d want 0 0", ndone, bad);
    end
    sb.delete();
    push_frame(2, 1);
    capture(1'b0, 30, -1, -1, '0, '0);
    for (int k = 0; k < 30; k++) begin
      if (cap_v[k]) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL rstmid_extra k=%0d got d=%h want no pixel", k, cap_d[k]);
        end else begin
          e = sb.pop_front();
          if (k != e.cyc || cap_d[k] !== e.data || cap_s[k] !== e.sof) begin
            n_fail++;
            $display("FAIL rstmid_pixel k=%0d d=%h sof=%b want k=%0d d=%h sof=%b", k, cap_d[k], cap_s[k], e.cyc, e.data, e.sof);
          end
        end
      end
    end
    n_tests++;
    if (sb.size() != 0 || cap_dn[27] !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_frame got left=%0d done27=%b want 0 1", sb.size(), cap_dn[27]);
    end
  endtask

  task automatic test_addr_oob();
    exp_t e;
    wr_en = 1'b1; wr_addr = AW'(25); wr_data = 32'hFFFF_FFFF;
    step();
    wr_addr = AW'(31);
    step();
    wr_en = 1'b0;
    sb.delete();
    push_frame(2, 1);
    capture(1'b0, 30, -1, -1, '0, '0);
    for (int k = 0; k < 30; k++) begin
      if (cap_v[k]) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL oob_extra k=%0d got d=%h want no pixel", k, cap_d[k]);
        end else begin
          e = sb.pop_front();
          if (k != e.cyc || cap_d[k] !== e.data || cap_s[k] !== e.sof) begin
            n_fail++;
            $display("FAIL oob_pixel k=%0d d=%h sof=%b want k=%0d d=%h sof=%b", k, cap_d[k], cap_s[k], e.cyc, e.data, e.sof);
          end
        end
      end
    end
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL oob_missing got %0d left want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    load_ram();
    step();
    test_stream_gap0();
    test_stream_gap2();
    test_busy_lockout();
    step();
    test_back_to_back();
    step();
    test_reset_mid();
    step();
    test_addr_oob();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/feature_map_streamer.md
Name: feature_map_streamer

Overview:
- Transmitter end of the layer streaming protocol: holds one input_x-by-input_y feature map in on-chip RAM and replays it as a raster stream of sof / output_valid / d_out.
- The output format is exactly what the pooling and convolution layers consume on sof / input_valid / d_in.
- Sits at the head of a layer chain, or between layers as a re-timing frame source.
- Loaded by a simple write port; each frame is launched by a start pulse.

Parameters:
- DATA_WIDTH, 32, width of each pixel word.
- input_x, 5, number of rows per frame.
- input_y, 5, pixels per row (line length; matches the line-buffer line width).
- GAP, 0, idle cycles inserted between consecutive valid pixels (0 = one pixel per cycle).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- wr_en  in  1  frame RAM write strobe.
- wr_addr  in  AW = $clog2(input_x*input_y)  pixel address, row*input_y + col.
- wr_data  in  DATA_WIDTH  pixel to store.
- start  in  1  launch one frame transmission.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last pixel.
- sof  out  1  high with the first valid pixel of a frame.
- output_valid  out  1  d_out carries a pixel.
- d_out  out  DATA_WIDTH  pixel data.

Behaviour:
- Reset (rst low, asynchronous):
  - busy, done, sof, output_valid, d_out = 0.
  - Address counter, gap counter and FSM return to IDLE.
  - RAM contents are not cleared.
- Reset mid-frame aborts the frame immediately. No done is issued, and the next frame needs a new start.
- Numbering: N = input_x*input_y. Edge E0 is the edge that samples start.
- FSM IDLE:
  - start high at E0 -> READ, and busy = 1 after E0.
  - start while busy is ignored.
  - start sampled in the same cycle that done is high is accepted (back-to-back frames).
- FSM READ:
  - Issues RAM read addresses 0..N-1 in raster order.
  - RAM read is synchronous with 1-cycle latency. d_out and output_valid are registered.
  - Latency: pixel 0 is valid in the cycle after E2. Pixel i is valid in the cycle after E(2 + i*(GAP+1)).
  - GAP>0: after each issued address the gap counter counts GAP cycles, and no address is issued meanwhile. output_valid is low during gap cycles and d_out holds the last pixel.
  - After address N-1 is issued -> DRAIN.
- FSM DRAIN:
  - Waits for the final pixel to leave the output register.
  - In the cycle after the last output_valid, done = 1 and busy = 0 -> IDLE.
- sof is asserted only together with output_valid of pixel 0, never otherwise.
- Writes:
  - wr_en accepted only while busy = 0. Writes while busy are dropped so the frame under transmission cannot be corrupted.
  - wr_addr >= N is dropped.
  - A write in the same cycle as an accepted start is performed (it lands before the first read).
- Widths: the address counter is AW bits and compares against N-1 (no wrap past N-1). The gap counter is $clog2(GAP+1) bits, with a minimum of 1.
- Output timing: no combinational path from any input to any output.

Decomposition:
- Shared include file: DATA_WIDTH default, address-width function/macro, FSM state encodings (IDLE, READ, DRAIN).
- One sub-module: frame_ram. Simple dual-port (1 write, 1 synchronous read), depth N, width DATA_WIDTH, no reset on the array.

Test Plan:
- 5x5, GAP=0, RAM loaded with 0..24, start pulse at E0 -> output_valid in cycles 2..26 after E0, d_out = 0..24 in order, sof only with d_out=0, done high at cycle 27 with busy falling the same cycle.
- 5x5, GAP=2, same data -> 25 valids at cycles 2,5,...,74, output_valid low in between, d_out held, done at cycle 75.
- start pulsed again at cycle 10 of a running frame; wr_en to addr 3 with 0xDEAD during the frame -> stream unchanged, 25 pixels, single done. A following frame still shows 3 at addr 3.
- start asserted on the done cycle -> second frame's pixel 0 is valid 2 cycles later with sof, no gap between frames beyond latency.
- rst low at cycle 12 of a frame -> all outputs 0 immediately, no done. A new start after release yields a full 25-pixel frame starting at 0.
- Write to wr_addr = 25 with 0xFFFF_FFFF, then stream -> all 25 pixels unchanged, no aliasing into addr 0.
